// File: rtl/sp_ram_banked_wrap_if.sv
// -----------------------------------------------------------------------------
// sp_ram_banked_wrap_if
//   Request/grant/response bus between the LSU/fetch interconnect (master) and
//   the banked SRAM wrapper (slave). Signal names keep their direction suffix
//   as seen from the RAM wrapper.
//
//   req_i       master -> slave  access request
//   gnt_o       slave  -> master request accepted this cycle (combinational)
//   addr_i      master -> slave  byte address
//   we_i        master -> slave  1 = write, 0 = read
//   be_i        master -> slave  byte enables (ignored on reads)
//   wdata_i     master -> slave  write data (also the bypass return data)
//   bypass_en_i master -> slave  return wdata_i instead of touching the array
//   rvalid_o    slave  -> master rdata_o valid
//   rdata_o     slave  -> master read data, held while rvalid_o is low
// -----------------------------------------------------------------------------
interface sp_ram_banked_wrap_if #(
  parameter int ADDR_WIDTH = 15,
  parameter int DATA_WIDTH = 32
);
  logic                    req_i;
  logic                    gnt_o;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic                    we_i;
  logic [DATA_WIDTH/8-1:0] be_i;
  logic [DATA_WIDTH-1:0]   wdata_i;
  logic                    bypass_en_i;
  logic                    rvalid_o;
  logic [DATA_WIDTH-1:0]   rdata_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i, bypass_en_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i, bypass_en_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/sp_ram_banked_wrap.sv
// -----------------------------------------------------------------------------
// sp_ram_banked_wrap
//   Parametrised banked single-port SRAM wrapper with request/grant/rvalid
//   handshake, write-data bypass, optional output register and a retention
//   sleep FSM (ACTIVE -> DRAIN -> SLEEP -> WAKE -> ACTIVE).
//
//   Ports:
//     clk      clock, rising edge
//     rstn_i   asynchronous active-low reset
//     bus      sp_ram_banked_wrap_if.slave (req/gnt/addr/we/be/wdata/
//              bypass_en/rvalid/rdata)
//     sleep_i  retention sleep request
//     idle_o   high only while in SLEEP
//     err_o    parity error pulse, coincident with rvalid_o
//
//   Optional feature macro: SP_RAM_PARITY_EN
//     defined   : one even-parity bit stored per data byte, checked on reads
//     undefined : no parity storage, err_o tied low
//
//   Assumes NUM_BANKS >= 2 and at least two rows per bank.
// -----------------------------------------------------------------------------
module sp_ram_banked_wrap #(
  parameter int RAM_SIZE    = 32768,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_BANKS   = 8,
  parameter int ADDR_WIDTH  = $clog2(RAM_SIZE),
  parameter int OUT_REG     = 0,
  parameter int WAKE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rstn_i,
  sp_ram_banked_wrap_if.slave    bus,
  input  logic                   sleep_i,
  output logic                   idle_o,
  output logic                   err_o
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int WIDX_W = ADDR_WIDTH - OFF_W;
  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int ROW_W  = WIDX_W - BANK_W;
  localparam int ROWS   = 1 << ROW_W;
  localparam int CNT_W  = $clog2(WAKE_CYCLES + 1);

  // ---------------------------------------------------------------- decode
  logic [WIDX_W-1:0] widx;
  logic [BANK_W-1:0] bank_sel;
  logic [ROW_W-1:0]  row_sel;

  assign widx     = bus.addr_i[ADDR_WIDTH-1:OFF_W];
  assign bank_sel = widx[WIDX_W-1 -: BANK_W];
  assign row_sel  = widx[ROW_W-1:0];

  if (OFF_W > 0) begin : g_off
    logic unused_offset;
    assign unused_offset = ^bus.addr_i[OFF_W-1:0];
  end

  // ---------------------------------------------------------- handshake
  typedef enum logic [1:0] {ST_ACTIVE, ST_DRAIN, ST_SLEEP, ST_WAKE} state_e;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  wake_cnt_q, wake_cnt_d;
  logic              gnt;
  logic              arr_wr, arr_rd;
  logic              inflight;
  logic              out_busy;

  assign gnt       = bus.req_i & (state_q == ST_ACTIVE) & ~sleep_i;
  assign bus.gnt_o = gnt;
  // Bypass never touches the array, whatever we_i says.
  assign arr_wr    = gnt &  bus.we_i & ~bus.bypass_en_i;
  assign arr_rd    = gnt & ~bus.we_i & ~bus.bypass_en_i;
  assign idle_o    = (state_q == ST_SLEEP);

  // --------------------------------------------------- response stage 1
  logic                  s1_valid_q, s1_byp_q;
  logic [BANK_W-1:0]     s1_bank_q;
  logic [DATA_WIDTH-1:0] s1_wdata_q;

  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      s1_valid_q <= 1'b0;
      s1_byp_q   <= 1'b0;
      s1_bank_q  <= '0;
      s1_wdata_q <= '0;
    end else begin
      // Plain writes produce no response; bypass writes do.
      s1_valid_q <= gnt & (~bus.we_i | bus.bypass_en_i);
      if (gnt) begin
        s1_byp_q   <= bus.bypass_en_i;
        s1_bank_q  <= bank_sel;
        s1_wdata_q <= bus.wdata_i;
      end
    end
  end

  // ---------------------------------------------------------------- banks
  logic [DATA_WIDTH-1:0] bank_rd [NUM_BANKS];
`ifdef SP_RAM_PARITY_EN
  logic [NUM_BANKS-1:0]  bank_perr;
`endif

  for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem [ROWS];
    logic [DATA_WIDTH-1:0] rd_q;
    logic                  sel;

    assign sel = (bank_sel == BANK_W'(gi));

    // Registered read; a read the cycle after a write sees the updated row.
    always_ff @(posedge clk) begin
      if (arr_wr && sel) begin
        for (int b = 0; b < BYTES; b++) begin
          if (bus.be_i[b]) mem[row_sel][b*8 +: 8] <= bus.wdata_i[b*8 +: 8];
        end
      end
      if (arr_rd && sel) rd_q <= mem[row_sel];
    end

    assign bank_rd[gi] = rd_q;

`ifdef SP_RAM_PARITY_EN
    logic [BYTES-1:0] par [ROWS];
    logic [BYTES-1:0] par_rd_q;
    logic [BYTES-1:0] wpar;
    logic             perr;

    always_comb begin
      wpar = '0;
      for (int b = 0; b < BYTES; b++) wpar[b] = ^bus.wdata_i[b*8 +: 8];
    end

    always_ff @(posedge clk) begin
      if (arr_wr && sel) begin
        for (int b = 0; b < BYTES; b++) begin
          if (bus.be_i[b]) par[row_sel][b] <= wpar[b];
        end
      end
      if (arr_rd && sel) par_rd_q <= par[row_sel];
    end

    always_comb begin
      perr = 1'b0;
      for (int b = 0; b < BYTES; b++) perr = perr | ((^rd_q[b*8 +: 8]) ^ par_rd_q[b]);
    end

    assign bank_perr[gi] = perr;
`endif
  end

  logic [DATA_WIDTH-1:0] s1_data;
  logic                  s1_err;

  assign s1_data = s1_byp_q ? s1_wdata_q : bank_rd[s1_bank_q];
`ifdef SP_RAM_PARITY_EN
  assign s1_err  = s1_valid_q & ~s1_byp_q & bank_perr[s1_bank_q];
`else
  assign s1_err  = 1'b0;
`endif

  // --------------------------------------------------------- output stage
  if (OUT_REG != 0) begin : g_oreg
    logic                  rvalid_q, err_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i) begin
        rvalid_q <= 1'b0;
        err_q    <= 1'b0;
        rdata_q  <= '0;
      end else begin
        rvalid_q <= s1_valid_q;
        err_q    <= s1_err;
        if (s1_valid_q) rdata_q <= s1_data;
      end
    end

    assign bus.rvalid_o = rvalid_q;
    assign bus.rdata_o  = rdata_q;
    assign err_o        = err_q;
    assign out_busy     = rvalid_q;
  end else begin : g_onoreg
    // The bank register feeds rdata_o directly; hold_q keeps the last
    // response visible once the bank register or mux select moves on.
    logic [DATA_WIDTH-1:0] hold_q;

    always_ff @(posedge clk or negedge rstn_i) begin
      if (!rstn_i)         hold_q <= '0;
      else if (s1_valid_q) hold_q <= s1_data;
    end

    assign bus.rvalid_o = s1_valid_q;
    assign bus.rdata_o  = s1_valid_q ? s1_data : hold_q;
    assign err_o        = s1_err;
    assign out_busy     = 1'b0;
  end

  assign inflight = s1_valid_q | out_busy;

  // ------------------------------------------------------------ power FSM
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= ST_ACTIVE;
      wake_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wake_cnt_q <= wake_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wake_cnt_d = wake_cnt_q;
    unique case (state_q)
      ST_ACTIVE: if (sleep_i) state_d = inflight ? ST_DRAIN : ST_SLEEP;
      ST_DRAIN:  if (!inflight) state_d = ST_SLEEP;
      ST_SLEEP: begin
        if (!sleep_i) begin
          state_d    = ST_WAKE;
          wake_cnt_d = '0;
        end
      end
      ST_WAKE: begin
        if (sleep_i) begin
          state_d    = ST_SLEEP;
          wake_cnt_d = '0;
        end else if (wake_cnt_q == CNT_W'(WAKE_CYCLES - 1)) begin
          state_d    = ST_ACTIVE;
          wake_cnt_d = '0;
        end else begin
          wake_cnt_d = wake_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_ACTIVE;
    endcase
  end
endmodule

// File: tb/tb_sp_ram_banked_wrap.sv
// -----------------------------------------------------------------------------
// tb_sp_ram_banked_wrap
//   Two instances (OUT_REG=0 and OUT_REG=1) driven with identical stimulus.
//   A byte-addressed model memory plus a per-instance response calendar
//   (slot = grant cycle + read latency) gives the expected rvalid/rdata/err
//   every cycle. Directed table, sleep/wake and reset sequences, then random.
// -----------------------------------------------------------------------------
module tb_sp_ram_banked_wrap;
  localparam int AW = 15;
  localparam int DW = 32;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic sleep;
  logic idle0, idle1, err0, err1;

  always #5 clk = ~clk;

  sp_ram_banked_wrap_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  sp_ram_banked_wrap_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  sp_ram_banked_wrap #(.OUT_REG(0)) dut0 (
    .clk(clk), .rstn_i(rstn), .bus(bus0),
    .sleep_i(sleep), .idle_o(idle0), .err_o(err0)
  );
  sp_ram_banked_wrap #(.OUT_REG(1)) dut1 (
    .clk(clk), .rstn_i(rstn), .bus(bus1),
    .sleep_i(sleep), .idle_o(idle1), .err_o(err1)
  );

  logic [1:0]  o_gnt, o_rv, o_err, o_idle;
  logic [31:0] o_rd [2];
  assign o_gnt  = {bus1.gnt_o, bus0.gnt_o};
  assign o_rv   = {bus1.rvalid_o, bus0.rvalid_o};
  assign o_err  = {err1, err0};
  assign o_idle = {idle1, idle0};
  assign o_rd[0] = bus0.rdata_o;
  assign o_rd[1] = bus1.rdata_o;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Model state
  logic [7:0]  mdl [int];
  bit          exp_v [2][8];
  logic [31:0] exp_d [2][8];
  bit          exp_e [2][8];
  logic [31:0] last_rd [2];
  bit          force_err = 1'b0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", name, d, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] mdl_word(input logic [14:0] a);
    logic [31:0] w;
    int base;
    base = int'(a) & ~3;
    w = 'x;
    for (int b = 0; b < 4; b++)
      if (mdl.exists(base + b)) w[b*8 +: 8] = mdl[base + b];
    return w;
  endfunction

  task automatic post(input logic [31:0] data, input bit e);
    for (int d = 0; d < 2; d++) begin
      exp_v[d][(cyc + 1 + d) % 8] = 1'b1;
      exp_d[d][(cyc + 1 + d) % 8] = data;
      exp_e[d][(cyc + 1 + d) % 8] = e;
    end
  endtask

  task automatic clear_model_pipe();
    for (int d = 0; d < 2; d++) begin
      last_rd[d] = 32'h0;
      for (int s = 0; s < 8; s++) exp_v[d][s] = 1'b0;
    end
  endtask

  task automatic drive(input bit req, input bit we, input logic [3:0] be, input logic [14:0] addr,
                       input logic [31:0] wd, input bit byp, input bit slp);
    bus0.req_i = req; bus0.we_i = we; bus0.be_i = be; bus0.addr_i = addr;
    bus0.wdata_i = wd; bus0.bypass_en_i = byp;
    bus1.req_i = req; bus1.we_i = we; bus1.be_i = be; bus1.addr_i = addr;
    bus1.wdata_i = wd; bus1.bypass_en_i = byp;
    sleep = slp;
  endtask

  // One clock cycle: drive, check grant/idle, update model, then check responses.
  task automatic cycle_run(input bit req, input bit we, input logic [3:0] be, input logic [14:0] addr,
                           input logic [31:0] wd, input bit byp, input bit slp,
                           input bit exp_gnt, input int exp_idle);
    int base;
    drive(req, we, be, addr, wd, byp, slp);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("gnt", d, o_gnt[d], exp_gnt);
      if (exp_idle >= 0) chk("idle", d, o_idle[d], exp_idle[0]);
    end
    if (exp_gnt) begin
      if (byp) post(wd, 1'b0);
      else if (we) begin
        base = int'(addr) & ~3;
        for (int b = 0; b < 4; b++) if (be[b]) mdl[base + b] = wd[b*8 +: 8];
      end else begin
        post(mdl_word(addr), force_err);
        force_err = 1'b0;
      end
    end
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (exp_v[d][cyc % 8]) begin
        chk("rvalid", d, o_rv[d], 1);
        chk("rdata", d, o_rd[d], exp_d[d][cyc % 8]);
        chk("err", d, o_err[d], exp_e[d][cyc % 8]);
        last_rd[d] = exp_d[d][cyc % 8];
        exp_v[d][cyc % 8] = 1'b0;
      end else begin
        chk("rvalid_idle", d, o_rv[d], 0);
        chk("rdata_hold", d, o_rd[d], last_rd[d]);
        chk("err_idle", d, o_err[d], 0);
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cycle_run(0, 0, 4'h0, 15'h0, 32'h0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit          we;
    bit          byp;
    logic [14:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          exp_rv;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        tbl [9];
  logic [14:0] pool [16];

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish within time budget");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 1'b0, 15'h0010, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 15'h0010, 4'hF, 32'h0,        1'b1, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 1'b0, 15'h0010, 4'h5, 32'h11223344, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 15'h0012, 4'h0, 32'h0,        1'b1, 32'hDE22BE44};
    tbl[4] = '{1'b1, 1'b0, 15'h7FFC, 4'hF, 32'h0A0B0C0D, 1'b0, 32'h0};
    tbl[5] = '{1'b1, 1'b1, 15'h0010, 4'hF, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
    tbl[6] = '{1'b0, 1'b1, 15'h7FFC, 4'hF, 32'h12345678, 1'b1, 32'h12345678};
    tbl[7] = '{1'b0, 1'b0, 15'h0010, 4'hF, 32'h0,        1'b1, 32'hDE22BE44};
    tbl[8] = '{1'b0, 1'b0, 15'h7FFC, 4'hF, 32'h0,        1'b1, 32'h0A0B0C0D};

    clear_model_pipe();
    drive(0, 0, 4'h0, 15'h0, 32'h0, 0, 0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_rvalid", d, o_rv[d], 0);
      chk("rst_rdata", d, o_rd[d], 32'h0);
      chk("rst_idle", d, o_idle[d], 0);
      chk("rst_err", d, o_err[d], 0);
      chk("rst_gnt", d, o_gnt[d], 0);
    end
    rstn = 1'b1;
    idle_cycles(2);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      cycle_run(1, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wd, tbl[i].byp, 0, 1, 0);
      idle_cycles(2);
      if (tbl[i].exp_rv)
        for (int d = 0; d < 2; d++) chk($sformatf("table%0d", i), d, o_rd[d], tbl[i].exp_rd);
    end

    // Back-to-back reads across banks 0 and 7
    cycle_run(1, 0, 4'hF, 15'h0010, 32'h0, 0, 0, 1, 0);
    cycle_run(1, 0, 4'hF, 15'h7FFC, 32'h0, 0, 0, 1, 0);
    idle_cycles(2);
    for (int d = 0; d < 2; d++) chk("b2b_last", d, o_rd[d], 32'h0A0B0C0D);

    // Sleep with a read in flight; req_i stays high and must be ignored
    cycle_run(1, 0, 4'hF, 15'h0010, 32'h0, 0, 0, 1, 0);
    for (int i = 0; i < 6; i++)
      cycle_run(1, 0, 4'hF, 15'h0010, 32'h0, 0, 1, 0, (i == 0) ? 0 : -1);
    for (int d = 0; d < 2; d++) chk("drain_to_sleep", d, o_idle[d], 1);
    for (int i = 0; i < 2; i++) cycle_run(1, 0, 4'hF, 15'h0010, 32'h0, 0, 1, 0, 1);
    // Release: grant exactly 5 cycles after the sleep_i fall, data retained
    for (int j = 0; j <= 5; j++)
      cycle_run(1, 0, 4'hF, 15'h7FFC, 32'h0, 0, 0, (j == 5), (j == 0) ? 1 : 0);
    idle_cycles(3);

    // Empty pipeline: straight to SLEEP; then sleep rise during WAKE
    cycle_run(0, 0, 4'h0, 15'h0, 32'h0, 0, 1, 0, 0);
    cycle_run(0, 0, 4'h0, 15'h0, 32'h0, 0, 1, 0, 1);
    cycle_run(0, 0, 4'h0, 15'h0, 32'h0, 0, 0, 0, 1);
    cycle_run(1, 0, 4'hF, 15'h0010, 32'h0, 0, 0, 0, 0);
    cycle_run(1, 0, 4'hF, 15'h0010, 32'h0, 0, 1, 0, 0);
    cycle_run(1, 0, 4'hF, 15'h0010, 32'h0, 0, 0, 0, 1);
    for (int j = 1; j <= 5; j++)
      cycle_run(1, 0, 4'hF, 15'h0010, 32'h0, 0, 0, (j == 5), 0);
    idle_cycles(3);

    // Reset one cycle after a read grant drops the read
    drive(1, 0, 4'hF, 15'h7FFC, 32'h0, 0, 0);
    #1;
    for (int d = 0; d < 2; d++) chk("rstmid_gnt", d, o_gnt[d], 1);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    drive(0, 0, 4'h0, 15'h0, 32'h0, 0, 0);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rstmid_rvalid", d, o_rv[d], 0);
      chk("rstmid_rdata", d, o_rd[d], 32'h0);
      chk("rstmid_err", d, o_err[d], 0);
      chk("rstmid_idle", d, o_idle[d], 0);
    end
    clear_model_pipe();
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    idle_cycles(3);
    cycle_run(1, 0, 4'hF, 15'h0010, 32'h0, 0, 0, 1, 0);
    idle_cycles(2);

    // Random traffic against the model
    for (int i = 0; i < 16; i++) begin
      pool[i] = {3'(i % 8), 10'($urandom), 2'b00};
      cycle_run(1, 1, 4'hF, pool[i], $urandom, 0, 0, 1, 0);
    end
    for (int i = 0; i < 400; i++) begin
      bit          r_req, r_we, r_byp;
      logic [14:0] r_addr;
      r_req  = ($urandom_range(0, 9) < 7);
      r_we   = $urandom_range(0, 1);
      r_byp  = ($urandom_range(0, 9) < 2);
      r_addr = pool[$urandom_range(0, 15)] | 15'($urandom_range(0, 3));
      cycle_run(r_req, r_we, 4'($urandom), r_addr, $urandom, r_byp, 0, r_req, 0);
    end
    idle_cycles(3);

`ifdef SP_RAM_PARITY_EN
    // Corrupt one stored bit behind the wrapper's back
    cycle_run(1, 1, 4'hF, 15'h0020, 32'h5A5A5A5A, 0, 0, 1, 0);
    dut0.g_bank[0].mem[8][3] = ~dut0.g_bank[0].mem[8][3];
    dut1.g_bank[0].mem[8][3] = ~dut1.g_bank[0].mem[8][3];
    mdl[32'h20] = mdl[32'h20] ^ 8'h08;
    force_err = 1'b1;
    cycle_run(1, 0, 4'hF, 15'h0020, 32'h0, 0, 0, 1, 0);
    idle_cycles(2);
    // Bypass never flags
    cycle_run(1, 0, 4'hF, 15'h0020, 32'h77777777, 1, 0, 1, 0);
    idle_cycles(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
